// File: rtl/mem_pkg.sv
// Shared constants, request-bus layout and FSM encoding for the memory responder.
package mem_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned BUS_W    = ADDR_W + 1 + DATA_W;

  localparam int unsigned ADDR_MSB = 13;
  localparam int unsigned ADDR_LSB = 9;
  localparam int unsigned WREN_BIT = 8;
  localparam int unsigned DATA_MSB = 7;

  // Field order matches ADDR_MSB..ADDR_LSB, WREN_BIT, DATA_MSB..0.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wren;
    logic [DATA_W-1:0] data;
  } ram_req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Cache-to-memory handshake: request level, request bus and response signals.
interface mem_responder_if;
  import mem_pkg::*;

  logic              req;
  logic [BUS_W-1:0]  RAM;
  logic [DATA_W-1:0] qRAM;
  logic              mem_access_done;
  logic              done_pulse;
  logic [1:0]        state;

  modport master (
    output req, RAM,
    input  qRAM, mem_access_done, done_pulse, state
  );

  modport slave (
    input  req, RAM,
    output qRAM, mem_access_done, done_pulse, state
  );

endinterface

// File: rtl/mem_array.sv
// Word storage: synchronous write, combinational read, reset loads mem[i] = i.
module mem_array #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= DATA_W'(i);
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: captures a request, waits LATENCY cycles,
// performs the access and holds DONE until the requester drops req.
module mem_responder #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned LATENCY = 3
) (
  input  logic            clock,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int unsigned CNT_W = 4;

  if (ADDR_W != mem_pkg::ADDR_W || DATA_W != mem_pkg::DATA_W) begin : g_bad_width
    $error("mem_responder: ADDR_W/DATA_W must match the request bus layout");
  end
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_responder: LATENCY must be in 1..15");
  end

  mem_pkg::state_e   state_q;
  mem_pkg::ram_req_t req_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] qram_q;
  logic              mad_q;
  logic              dp_q;
  logic [DATA_W-1:0] rdata;
  logic              we_c;

  // Write lands on the same edge that leaves BUSY, so a reset during BUSY drops it.
  assign we_c = (state_q == mem_pkg::ST_BUSY) && (cnt_q == '0) && req_q.wren;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .we_i    (we_c),
    .addr_i  (req_q.addr),
    .wdata_i (req_q.data),
    .rdata_o (rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= mem_pkg::ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      qram_q  <= '0;
      mad_q   <= 1'b1;
      dp_q    <= 1'b0;
    end else begin
      dp_q <= 1'b0;
      case (state_q)
        mem_pkg::ST_IDLE: begin
          if (bus.req) begin
            req_q   <= mem_pkg::ram_req_t'(bus.RAM);
            cnt_q   <= CNT_W'(LATENCY - 1);
            mad_q   <= 1'b0;
            state_q <= mem_pkg::ST_BUSY;
          end
        end
        mem_pkg::ST_BUSY: begin
          if (cnt_q == '0) begin
            qram_q  <= req_q.wren ? req_q.data : rdata;
            mad_q   <= 1'b1;
            dp_q    <= 1'b1;
            state_q <= mem_pkg::ST_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        mem_pkg::ST_DONE: begin
          if (!bus.req) begin
            state_q <= mem_pkg::ST_IDLE;
          end
        end
        default: begin
          mad_q   <= 1'b1;
          state_q <= mem_pkg::ST_IDLE;
        end
      endcase
    end
  end

  assign bus.qRAM            = qram_q;
  assign bus.mem_access_done = mad_q;
  assign bus.done_pulse      = dp_q;
  assign bus.state           = 2'(state_q);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table plus hand-written corner sequences.
module tb_mem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();

  mem_responder #(.ADDR_W(5), .DATA_W(8), .LATENCY(3)) u_dut3 (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus0.slave)
  );

  mem_responder #(.ADDR_W(5), .DATA_W(8), .LATENCY(1)) u_dut1 (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus1.slave)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit sel = 1'b0;

  typedef struct {
    logic       wren;
    logic [4:0] addr;
    logic [7:0] data;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] q_s();
    return sel ? bus1.qRAM : bus0.qRAM;
  endfunction
  function automatic logic [1:0] st_s();
    return sel ? bus1.state : bus0.state;
  endfunction
  function automatic logic mad_s();
    return sel ? bus1.mem_access_done : bus0.mem_access_done;
  endfunction
  function automatic logic dp_s();
    return sel ? bus1.done_pulse : bus0.done_pulse;
  endfunction

  task automatic drive(input logic r, input logic [13:0] b);
    if (sel) begin
      bus1.req = r;
      bus1.RAM = b;
    end else begin
      bus0.req = r;
      bus0.RAM = b;
    end
  endtask

  // Full four-phase access; hold = extra cycles req stays high in DONE.
  task automatic access(input string nm, input logic wren, input logic [4:0] addr,
                        input logic [7:0] data, input int hold, input int lat,
                        output logic [7:0] q);
    int busy;
    int pulses;
    bit got;
    @(negedge clk);
    drive(1'b1, {addr, wren, data});
    busy = 0; pulses = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (!mad_s()) busy++;
      if (dp_s()) begin
        pulses++;
        got = 1'b1;
      end
    end
    chk({nm, " done_seen"}, int'(got), 1);
    chk({nm, " busy_cycles"}, busy, lat);
    chk({nm, " state_done"}, int'(st_s()), 2);
    q = q_s();
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (dp_s()) pulses++;
      chk({nm, " state_held"}, int'(st_s()), 2);
    end
    drive(1'b0, {addr, wren, data});
    @(negedge clk);
    chk({nm, " pulse_count"}, pulses, 1);
    chk({nm, " state_idle"}, int'(st_s()), 0);
    chk({nm, " mad_idle"}, int'(mad_s()), 1);
  endtask

  initial begin
    logic [7:0] q;
    int to;
    vecs[0] = '{1'b0, 5'h05, 8'h00, 8'h05};
    vecs[1] = '{1'b1, 5'h1F, 8'hA7, 8'hA7};
    vecs[2] = '{1'b0, 5'h1F, 8'h00, 8'hA7};
    vecs[3] = '{1'b0, 5'h00, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 5'h03, 8'h55, 8'h55};
    vecs[5] = '{1'b0, 5'h03, 8'h00, 8'h55};
    vecs[6] = '{1'b0, 5'h10, 8'h00, 8'h10};
    vecs[7] = '{1'b1, 5'h00, 8'hFF, 8'hFF};
    vecs[8] = '{1'b0, 5'h00, 8'h00, 8'hFF};

    rst_n = 1'b0;
    sel = 1'b0; drive(1'b0, 14'h0);
    sel = 1'b1; drive(1'b0, 14'h0);
    sel = 1'b0;
    #12;
    chk("rst state", int'(bus0.state), 0);
    chk("rst qRAM", int'(bus0.qRAM), 0);
    chk("rst mad", int'(bus0.mem_access_done), 1);
    chk("rst pulse", int'(bus0.done_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      access($sformatf("vec%0d", v), vecs[v].wren, vecs[v].addr, vecs[v].data, 0, 3, q);
      chk($sformatf("vec%0d qRAM", v), int'(q), int'(vecs[v].exp_q));
    end

    // Bus changes mid-BUSY must be ignored.
    @(negedge clk);
    drive(1'b1, {5'd9, 1'b0, 8'h00});
    @(negedge clk);
    drive(1'b1, {5'd2, 1'b1, 8'hEE});
    to = 0;
    while (!bus0.done_pulse && to < 40) begin
      @(negedge clk);
      to++;
    end
    chk("midbusy done_seen", int'(bus0.done_pulse), 1);
    chk("midbusy qRAM", int'(bus0.qRAM), 8'h09);
    drive(1'b0, 14'h0);
    @(negedge clk);
    access("midbusy addr2", 1'b0, 5'd2, 8'h00, 0, 3, q);
    chk("midbusy addr2 qRAM", int'(q), 8'h02);

    // req held high in DONE for 5 cycles.
    access("hold", 1'b0, 5'd7, 8'h00, 5, 3, q);
    chk("hold qRAM", int'(q), 8'h07);
    chk("hold qRAM after idle", int'(bus0.qRAM), 8'h07);

    // Reset during BUSY of a write aborts it.
    @(negedge clk);
    drive(1'b1, {5'd4, 1'b1, 8'h3C});
    @(negedge clk);
    chk("abort in busy", int'(bus0.state), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort state", int'(bus0.state), 0);
    chk("abort mad", int'(bus0.mem_access_done), 1);
    chk("abort qRAM", int'(bus0.qRAM), 0);
    drive(1'b0, 14'h0);
    @(negedge clk);
    rst_n = 1'b1;
    access("abort rd4", 1'b0, 5'd4, 8'h00, 0, 3, q);
    chk("abort rd4 qRAM", int'(q), 8'h04);
    access("reinit rd1F", 1'b0, 5'h1F, 8'h00, 0, 3, q);
    chk("reinit rd1F qRAM", int'(q), 8'h1F);

    // LATENCY=1 instance, back-to-back reads.
    sel = 1'b1;
    access("lat1 rd1", 1'b0, 5'd1, 8'h00, 0, 1, q);
    chk("lat1 rd1 qRAM", int'(q), 8'h01);
    access("lat1 rd2", 1'b0, 5'd2, 8'h00, 0, 1, q);
    chk("lat1 rd2 qRAM", int'(q), 8'h02);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
